usart_rx: RTL and testbench

USART_RX -- requirements
Module: usart_rx

---
 rtl/usart_pkg.sv | 18 +
 rtl/usart_sync2.sv | 12 +
 rtl/usart_rx.sv | 101 ++++++++++
 tb/tb_usart_rx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usart_pkg.sv
// usart_pkg: receiver/transmitter state encoding, character-length codes and oversample default
package usart_pkg;
  localparam int OVERSAMPLE_DEF = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} usart_state_t;
  localparam logic [1:0] CL5 = 2'b00;
  localparam logic [1:0] CL6 = 2'b01;
  localparam logic [1:0] CL7 = 2'b10;
  localparam logic [1:0] CL8 = 2'b11;
  function automatic logic [3:0] data_bits(input logic [1:0] char_len);
    case (char_len)
      CL5: return 4'd5;
      CL6: return 4'd6;
      CL7: return 4'd7;
      CL8: return 4'd8;
      default: return 4'd8;
    endcase
  endfunction
endpackage

// File: rtl/usart_sync2.sv
// usart_sync2: two-flop synchronizer, resets to the idle-high line level
module usart_sync2 (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or posedge reset)
    if (reset) {q, m} <= 2'b11;
    else {q, m} <= {m, d};
endmodule

// File: rtl/usart_rx.sv
// usart_rx: oversampling asynchronous serial receiver with sticky error flags.
// Parity receive logic is built only when USART_RX_PARITY_EN is defined.
module usart_rx
  import usart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_clk_en,
  input  logic       rxd,
  input  logic       rx_en,
  input  logic [1:0] char_len,
  input  logic       pen,
  input  logic       ep,
  input  logic       rd_strobe,
  input  logic       err_reset,
  output logic [7:0] rx_data,
  output logic       rx_rdy,
  output logic       pe,
  output logic       fe,
  output logic       oe,
  output logic       busy
);
  localparam int CW = $clog2(OVERSAMPLE);
  usart_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [7:0] sr;
  logic [2:0] idx;
  logic [1:0] len_q;
  logic rxs, rxs_q, samp, go, last_bit, par_on, load, pe_set;

  usart_sync2 u_sync (.clk(clk), .reset(reset), .d(rxd), .q(rxs));

  // START samples at mid-bit, every later state one full bit period apart
  assign samp = rx_en && rx_clk_en && state != IDLE &&
                cnt == CW'(state == START ? OVERSAMPLE / 2 - 1 : OVERSAMPLE - 1);
  assign go = samp && state == START && !rxs;
  assign last_bit = idx == 3'(data_bits(len_q) - 4'd1);
  assign load = samp && state == STOP;
  assign busy = state != IDLE;

`ifdef USART_RX_PARITY_EN
  logic pen_q, ep_q, pe_pend;
  assign par_on = pen_q;
  assign pe_set = load && pen_q && pe_pend;
  always_ff @(posedge clk or posedge reset)
    if (reset) {pen_q, ep_q, pe_pend} <= '0;
    else if (go) {pen_q, ep_q, pe_pend} <= {pen, ep, 1'b0};
    else if (samp && state == PARITY) pe_pend <= ^sr ^ rxs ^ ~ep_q;
`else
  logic unused_par;
  assign unused_par = pen ^ ep;
  assign par_on = 1'b0;
  assign pe_set = 1'b0;
`endif

  always_comb begin
    state_n = state;
    if (!rx_en) state_n = IDLE;
    else if (state == IDLE) state_n = (rxs_q && !rxs) ? START : IDLE;
    else if (samp)
      case (state)
        START:   state_n = rxs ? IDLE : DATA;
        DATA:    state_n = !last_bit ? DATA : par_on ? PARITY : STOP;
        default: state_n = state == PARITY ? STOP : IDLE;
      endcase
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      rxs_q <= 1'b1;
      sr <= '0;
      idx <= '0;
      len_q <= '0;
      rx_data <= '0;
      rx_rdy <= 1'b0;
      pe <= 1'b0;
      fe <= 1'b0;
      oe <= 1'b0;
    end else begin
      state <= state_n;
      rxs_q <= rxs;
      cnt <= (state == IDLE || samp || !rx_en) ? '0 : cnt + CW'(rx_clk_en);
      if (go) begin
        sr <= '0;
        idx <= '0;
        len_q <= char_len;
      end else if (samp && state == DATA) begin
        sr[idx] <= rxs;
        idx <= idx + 3'd1;
      end
      if (load) rx_data <= sr;
      rx_rdy <= load || (rx_rdy && !rd_strobe);
      pe <= pe_set || (pe && !err_reset);
      fe <= (load && !rxs) || (fe && !err_reset);
      oe <= (load && rx_rdy && !rd_strobe) || (oe && !err_reset);
    end
endmodule

// File: tb/tb_usart_rx.sv
// tb_usart_rx: directed and randomized frames checked against a frame-level output model
module tb_usart_rx;
  localparam int OS = 16;
  localparam int DIV = 3;
  localparam int BIT = OS * DIV;
`ifdef USART_RX_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  logic clk = 1'b0, reset = 1'b1, rx_clk_en = 1'b0, rxd = 1'b1, rx_en = 1'b0;
  logic pen = 1'b0, ep = 1'b0, rd_strobe = 1'b0, err_reset = 1'b0;
  logic [1:0] char_len = 2'b11;
  logic [7:0] rx_data;
  logic rx_rdy, pe, fe, oe, busy;
  int n_tests = 0, n_fail = 0, tick_total = 0, tdiv = 0;
  logic [7:0] m_data = '0;
  logic m_rdy = 1'b0, m_pe = 1'b0, m_fe = 1'b0, m_oe = 1'b0, m_busy = 1'b0;
  bit chk_en = 1'b0;

  usart_rx #(.OVERSAMPLE(OS)) dut (
    .clk(clk), .reset(reset), .rx_clk_en(rx_clk_en), .rxd(rxd), .rx_en(rx_en),
    .char_len(char_len), .pen(pen), .ep(ep), .rd_strobe(rd_strobe), .err_reset(err_reset),
    .rx_data(rx_data), .rx_rdy(rx_rdy), .pe(pe), .fe(fe), .oe(oe), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    tdiv = (tdiv + 1) % DIV;
    rx_clk_en = tdiv == 0;
  end

  always @(posedge clk) tick_total <= tick_total + int'(rx_clk_en);

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      n_tests++;
      if ({rx_data, rx_rdy, pe, fe, oe, busy} !== {m_data, m_rdy, m_pe, m_fe, m_oe, m_busy}) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t got data=%h rdy=%b pe=%b fe=%b oe=%b busy=%b expected data=%h rdy=%b pe=%b fe=%b oe=%b busy=%b",
                 $time, rx_data, rx_rdy, pe, fe, oe, busy, m_data, m_rdy, m_pe, m_fe, m_oe, m_busy);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mask8(input int n);
    return 8'((1 << n) - 1);
  endfunction

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic window(input int n);
    chk_en = 1'b1;
    cyc(n);
    chk_en = 1'b0;
  endtask

  // Stop mid-sample falls on tick OS/2 + OS*(bits+1) after the synchronized start edge
  task automatic stop_watch(input int nb, input bit rd, input bit er, input bit probe);
    int target;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    target = tick_total + OS / 2 + OS * (nb + 1);
    do @(negedge clk); while (!(rx_clk_en && tick_total + 1 == target));
    rd_strobe = rd;
    err_reset = er;
    @(negedge clk);
    rd_strobe = 1'b0;
    err_reset = 1'b0;
    if (probe) begin
      @(negedge clk);
      chk("rdy_within_2clk", {7'b0, rx_rdy}, 8'h01);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input int n, input bit par, input bit pbit,
                            input bit stop, input int ab, input bit rd, input bit er, input bit probe);
    rxd = 1'b0;
    fork
      stop_watch(n + int'(par), rd, er, probe);
    join_none
    cyc(BIT);
    m_busy = 1'b1;
    for (int i = 0; i < n; i++) begin
      rxd = d[i];
      if (i == 1) begin
        char_len = 2'($urandom);
        pen = 1'($urandom);
        ep = 1'($urandom);
      end
      chk_en = 1'b1;
      if (i == ab) begin
        cyc(BIT / 2);
        rx_en = 1'b0;
        m_busy = 1'b0;
        cyc(BIT - BIT / 2);
      end else cyc(BIT);
    end
    chk_en = 1'b0;
    if (par) begin
      rxd = pbit;
      cyc(BIT);
    end
    rxd = stop;
    cyc(BIT);
  endtask

  task automatic frame(input logic [7:0] d, input logic [1:0] cl, input bit pen_i, input bit ep_i,
                       input bit flip, input bit stop, input int ab, input bit rd, input bit er, input bit probe);
    int n;
    bit par, good, os;
    char_len = cl;
    pen = pen_i;
    ep = ep_i;
    n = 5 + int'(cl);
    par = PAR && pen_i;
    good = (^(d & mask8(n))) ^ !ep_i;
    send_frame(d, n, par, good ^ flip, (ab >= 0) ? 1'b1 : stop, ab, ab < 0 && rd, ab < 0 && er, probe);
    if (ab >= 0) rx_en = 1'b1;
    else begin
      os = m_rdy && !rd;
      m_data = d & mask8(n);
      m_rdy = 1'b1;
      m_fe = !stop || (m_fe && !er);
      m_pe = (par && flip) || (m_pe && !er);
      m_oe = os || (m_oe && !er);
    end
    m_busy = 1'b0;
  endtask

  task automatic gap(input bit rd, input bit er);
    rxd = 1'b1;
    window(6);
    if (rd || er) begin
      rd_strobe = rd;
      err_reset = er;
      cyc(1);
      rd_strobe = 1'b0;
      err_reset = 1'b0;
      if (rd) m_rdy = 1'b0;
      if (er) {m_pe, m_fe, m_oe} = 3'b000;
    end
    window(6);
  endtask

  initial begin
    cyc(3);
    window(3);
    chk("reset_data", rx_data, 8'h00);
    chk("reset_status", {3'b0, rx_rdy, pe, fe, oe, busy}, 8'h00);
    reset = 1'b0;
    rx_en = 1'b1;
    cyc(BIT);

    frame(8'h55, 2'b11, 0, 0, 0, 1, -1, 0, 0, 1);
    chk("8n1_55_data", rx_data, 8'h55);
    chk("8n1_55_flags", {5'b0, pe, fe, oe}, 8'h00);
    gap(1, 0);

    frame(8'h41, 2'b10, 1, 1, 1, 1, -1, 0, 0, 0);
    chk("7e1_41_data", rx_data, 8'h41);
    chk("7e1_41_pe", {7'b0, pe}, {7'b0, PAR});
    gap(1, 1);
    chk("7e1_err_reset_pe", {7'b0, pe}, 8'h00);

    frame(8'hA3, 2'b11, 0, 0, 0, 0, -1, 0, 0, 0);
    chk("break_a3_data", rx_data, 8'hA3);
    chk("break_a3_fe", {7'b0, fe}, 8'h01);
    window(3 * BIT);
    chk("break_no_second", {6'b0, rx_rdy, oe}, 8'h02);
    gap(1, 1);

    frame(8'h11, 2'b11, 0, 0, 0, 1, -1, 0, 0, 0);
    gap(0, 0);
    frame(8'h22, 2'b11, 0, 0, 0, 1, -1, 0, 0, 0);
    chk("overrun_data", rx_data, 8'h22);
    chk("overrun_oe", {7'b0, oe}, 8'h01);
    gap(1, 1);

    frame(8'h11, 2'b11, 0, 0, 0, 1, -1, 0, 0, 0);
    gap(0, 0);
    frame(8'h22, 2'b11, 0, 0, 0, 1, -1, 1, 0, 0);
    chk("rd_at_stop_rdy_oe", {6'b0, rx_rdy, oe}, 8'h02);
    gap(1, 1);

    rxd = 1'b0;
    cyc(4 * DIV);
    rxd = 1'b1;
    cyc(BIT);
    window(6);
    chk("false_start", {4'b0, rx_rdy, pe, fe, busy}, 8'h00);

    char_len = 2'b11;
    pen = 1'b0;
    rxd = 1'b0;
    cyc(BIT);
    rxd = 1'b1;
    cyc(3 * BIT);
    reset = 1'b1;
    {m_data, m_rdy, m_pe, m_fe, m_oe, m_busy} = '0;
    window(3);
    chk("mid_reset_data", rx_data, 8'h00);
    chk("mid_reset_busy", {7'b0, busy}, 8'h00);
    reset = 1'b0;
    cyc(6 * BIT);
    window(4);
    frame(8'h5A, 2'b11, 0, 0, 0, 1, -1, 0, 0, 0);
    chk("after_reset_5a", rx_data, 8'h5A);
    gap(1, 1);

    for (int k = 0; k < 40; k++) begin
      logic [7:0] d;
      logic [1:0] cl;
      int n, ab;
      d = 8'($urandom);
      cl = 2'($urandom);
      n = 5 + int'(cl);
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1;
      frame(d, cl, 1'($urandom), 1'($urandom), $urandom_range(0, 3) == 0, $urandom_range(0, 5) != 0,
            ab, $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0, 0);
      gap($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
